// File: rtl/xadac_ex_if.sv
// Shared xadac execute-interface package: vector/address/ID widths and the
// common bus types, plus the narrow-beat definitions used by the OBI downsizer.
package xadac_ex_if;

  localparam int VectorWidth     = 256;
  localparam int AddrWidth       = 32;
  localparam int IdWidth         = 4;
  localparam int DownNarrowWidth = 32;
  localparam int DownBeats       = VectorWidth / DownNarrowWidth;

  typedef logic [AddrWidth-1:0]         AddrT;
  typedef logic [IdWidth-1:0]           IdT;
  typedef logic [VectorWidth-1:0]       VectorT;
  typedef logic [VectorWidth/8-1:0]     BeT;
  typedef logic [$clog2(DownBeats)-1:0] DownBeatIdxT;

endpackage

// File: rtl/xadac_obi_downsizer_pkg.sv
// Local definitions for the wide-to-narrow OBI downsizer (FSM state encoding).
package xadac_obi_downsizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/xadac_obi_downsizer_if.sv
// Bundle of the wide (s_*) and narrow (m_*) OBI signals around the downsizer.
// slave = downsizer view, master = upstream unit plus memory view.
interface xadac_obi_downsizer_if #(
  parameter int VectorWidth = xadac_ex_if::VectorWidth,
  parameter int NarrowWidth = xadac_ex_if::DownNarrowWidth,
  parameter int AddrWidth   = xadac_ex_if::AddrWidth,
  parameter int IdWidth     = xadac_ex_if::IdWidth
);

  logic                       s_req;
  logic                       s_gnt;
  logic [AddrWidth-1:0]       s_addr;
  logic                       s_we;
  logic [VectorWidth/8-1:0]   s_be;
  logic [VectorWidth-1:0]     s_wdata;
  logic [IdWidth-1:0]         s_aid;
  logic                       s_rvalid;
  logic                       s_rready;
  logic [VectorWidth-1:0]     s_rdata;
  logic [IdWidth-1:0]         s_rid;
  logic                       s_err;

  logic                       m_req;
  logic                       m_gnt;
  logic [AddrWidth-1:0]       m_addr;
  logic                       m_we;
  logic [NarrowWidth/8-1:0]   m_be;
  logic [NarrowWidth-1:0]     m_wdata;
  logic                       m_rvalid;
  logic [NarrowWidth-1:0]     m_rdata;
  logic                       m_err;

  modport slave (
    input  s_req, s_addr, s_we, s_be, s_wdata, s_aid, s_rready,
    output s_gnt, s_rvalid, s_rdata, s_rid, s_err,
    output m_req, m_addr, m_we, m_be, m_wdata,
    input  m_gnt, m_rvalid, m_rdata, m_err
  );

  modport master (
    output s_req, s_addr, s_we, s_be, s_wdata, s_aid, s_rready,
    input  s_gnt, s_rvalid, s_rdata, s_rid, s_err,
    input  m_req, m_addr, m_we, m_be, m_wdata,
    output m_gnt, m_rvalid, m_rdata, m_err
  );

endinterface

// File: rtl/xadac_beat_picker.sv
// Combinational search for the lowest beat index >= from whose byte-enable
// slice is non-zero; none = 1 when no such beat exists.
module xadac_beat_picker #(
  parameter int N  = 8,
  parameter int NB = 4,
  parameter int KW = 3
) (
  input  logic [N*NB-1:0] be,
  input  logic [KW:0]     from,
  output logic [KW-1:0]   idx,
  output logic            none
);

  // Scanning downwards leaves the lowest qualifying index as the final winner.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && (|be[i*NB +: NB])) begin
        idx  = KW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xadac_obi_downsizer.sv
// Splits one wide OBI transaction into narrow beats and returns one wide response.
// Define XADAC_OBI_SKIP_EMPTY_EN to skip beats whose byte-enable slice is zero.
module xadac_obi_downsizer
  import xadac_obi_downsizer_pkg::*;
#(
  parameter int VectorWidth = xadac_ex_if::VectorWidth,
  parameter int NarrowWidth = xadac_ex_if::DownNarrowWidth,
  parameter int AddrWidth   = xadac_ex_if::AddrWidth,
  parameter int IdWidth     = xadac_ex_if::IdWidth
) (
  input logic                  clk,
  input logic                  rst,
  xadac_obi_downsizer_if.slave bus
);

  localparam int N  = VectorWidth / NarrowWidth;
  localparam int NB = NarrowWidth / 8;
  localparam int BW = VectorWidth / 8;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(NB - 1);

  function automatic logic [AddrWidth-1:0] beat_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [KW-1:0]        k);
    beat_addr = base + AddrWidth'(k) * AddrWidth'(NB);
  endfunction

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [KW-1:0]          pick_idx;
  logic                   pick_none;
  logic                   accept;

  logic [AddrWidth-1:0]   base_q, base_src;
  logic                   we_q, we_src;
  logic [BW-1:0]          be_q, be_src;
  logic [VectorWidth-1:0] wdata_q, wdata_src;
  logic [IdWidth-1:0]     aid_q;
  logic [VectorWidth-1:0] rdata_q;
  logic                   err_q;

  logic                   s_gnt_q, s_gnt_d;
  logic                   s_rvalid_q, s_rvalid_d;
  logic                   m_req_q, m_req_d;
  logic                   m_we_q, m_we_d;
  logic [AddrWidth-1:0]   m_addr_q, m_addr_d;
  logic [NB-1:0]          m_be_q, m_be_d;
  logic [NarrowWidth-1:0] m_wdata_q, m_wdata_d;

  assign accept = (state_q == IDLE) && s_gnt_q && bus.s_req;

  // In IDLE the first beat is built from the live request, later beats from the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      base_src  = bus.s_addr & AlignMask;
      we_src    = bus.s_we;
      be_src    = bus.s_be;
      wdata_src = bus.s_wdata;
    end else begin
      base_src  = base_q;
      we_src    = we_q;
      be_src    = be_q;
      wdata_src = wdata_q;
    end
  end

`ifdef XADAC_OBI_SKIP_EMPTY_EN
  logic [KW:0] pick_from;
  assign pick_from = (state_q == IDLE) ? '0 : ((KW+1)'(k_q) + (KW+1)'(1));

  xadac_beat_picker #(
    .N  (N),
    .NB (NB),
    .KW (KW)
  ) u_picker (
    .be   (be_src),
    .from (pick_from),
    .idx  (pick_idx),
    .none (pick_none)
  );
`else
  assign pick_idx  = (state_q == IDLE) ? '0 : (k_q + KW'(1));
  assign pick_none = (state_q != IDLE) && (k_q == KW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          k_d     = pick_idx;
          state_d = pick_none ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          if (pick_none) begin
            state_d = RESP;
          end else begin
            k_d     = pick_idx;
            state_d = ISSUE;
          end
        end
      end
      RESP: begin
        if (bus.s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Narrow request fields load only on entry to ISSUE, so they hold while m_gnt is low.
  always_comb begin
    s_gnt_d    = (state_d == IDLE);
    s_rvalid_d = (state_d == RESP);
    m_req_d    = (state_d == ISSUE);
    m_addr_d   = m_addr_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_wdata_d  = m_wdata_q;
    if ((state_d == ISSUE) && (state_q != ISSUE)) begin
      m_addr_d  = beat_addr(base_src, k_d);
      m_we_d    = we_src;
      m_be_d    = be_src[int'(k_d)*NB +: NB];
      m_wdata_d = wdata_src[int'(k_d)*NarrowWidth +: NarrowWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_gnt_q    <= 1'b0;
      s_rvalid_q <= 1'b0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_wdata_q  <= '0;
    end else begin
      s_gnt_q    <= s_gnt_d;
      s_rvalid_q <= s_rvalid_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= base_src;
      we_q    <= bus.s_we;
      be_q    <= bus.s_be;
      wdata_q <= bus.s_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      aid_q   <= bus.s_aid;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == WAIT) && bus.m_rvalid) begin
      if (!we_q) rdata_q[int'(k_q)*NarrowWidth +: NarrowWidth] <= bus.m_rdata;
      err_q <= err_q | bus.m_err;
    end
  end

  assign bus.s_gnt    = s_gnt_q;
  assign bus.s_rvalid = s_rvalid_q;
  assign bus.s_rdata  = rdata_q;
  assign bus.s_rid    = aid_q;
  assign bus.s_err    = err_q;
  assign bus.m_req    = m_req_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_be     = m_be_q;
  assign bus.m_wdata  = m_wdata_q;

endmodule

// File: doc/xadac_obi_downsizer.md
# xadac_obi_downsizer

Converts one wide vector OBI transaction (VectorWidth data, per-byte enables, transaction ID) into a sequence of narrow OBI beats toward the data memory port. It then returns a single wide response carrying the original ID. It sits directly downstream of the xadac vector execute units (activation store, vector load) and upstream of the core data-memory interconnect. It handles one wide transaction at a time.

## Interface
- VectorWidth, default xadac_ex_if::VectorWidth (256): wide data width, bits.
- NarrowWidth, default 32: memory port data width, bits. VectorWidth must be a multiple of it.
- AddrWidth, default xadac_ex_if::AddrWidth (32): address width.
- IdWidth, default xadac_ex_if::IdWidth: transaction ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_req  in  1  wide request valid.
- s_gnt  out  1  wide request accepted.
- s_addr  in  AddrWidth  wide byte address.
- s_we  in  1  1 = write.
- s_be  in  VectorWidth/8  byte enables.
- s_wdata  in  VectorWidth  write data.
- s_aid  in  IdWidth  request ID.
- s_rvalid  out  1  wide response valid.
- s_rready  in  1  wide response accepted.
- s_rdata  out  VectorWidth  read data.
- s_rid  out  IdWidth  response ID (= accepted s_aid).
- s_err  out  1  OR of all beat errors.
- m_req  out  1  narrow request.
- m_gnt  in  1  narrow grant.
- m_addr  out  AddrWidth  narrow address.
- m_we  out  1  narrow write enable.
- m_be  out  NarrowWidth/8  narrow byte enables.
- m_wdata  out  NarrowWidth  narrow write data.
- m_rvalid  in  1  narrow response valid.
- m_rdata  in  NarrowWidth  narrow read data.
- m_err  in  1  narrow error, sampled with m_rvalid.

## Operation
- Beats N = VectorWidth/NarrowWidth, NB = NarrowWidth/8. Beat k uses s_be/s_wdata slice k (LSB slice first).
- Beat address = {s_addr[AddrWidth-1:log2 NB], 0} + k·NB. Low address bits are ignored. Address arithmetic wraps modulo 2^AddrWidth.
- FSM states:
  - IDLE: s_gnt = 1. On s_req, latch addr/we/be/wdata/aid, clear rdata and err, set k to the first beat to issue, and go to ISSUE.
  - ISSUE: m_req = 1 with beat-k fields. On m_gnt, go to WAIT.
  - WAIT: on m_rvalid, store m_rdata into rdata slice k (reads only) and OR m_err into err. If a further beat remains, advance k and go to ISSUE. Otherwise go to RESP.
  - RESP: s_rvalid = 1. On s_rready, go to IDLE.
- m_req, m_addr, m_be, m_wdata and m_we are registered. They stay stable while m_req is high without m_gnt.
- For reads, bytes of non-issued beats return 0.
- Reset values of all outputs are 0: s_gnt, s_rvalid, s_rdata, s_rid, s_err, m_req, m_addr, m_we, m_be, m_wdata. The state returns to IDLE.
- Reset mid-transaction abandons the transaction. Any m_rvalid arriving later is ignored in IDLE. The interconnect is reset together with this block.
- m_rvalid outside WAIT is ignored.

## Timing
- s_gnt = (state == IDLE). It is registered and has no combinational path from s_req.
- Accept at cycle 0. Beat 0 m_req is asserted at cycle 1.
- With zero-wait memory (m_gnt same cycle, m_rvalid next cycle), each beat takes 2 cycles. s_rvalid rises at cycle 2·(issued beats)+1.
- Back-to-back: s_gnt returns in the cycle after the s_rready handshake.

## Configuration
- XADAC_OBI_SKIP_EMPTY_EN defined: beats whose byte-enable slice is all zero are not issued, for both reads and writes.
  - If all s_be bits are zero, no narrow beat is issued and s_rvalid is asserted at cycle 1.
- Not defined: all N beats are always issued, including those with m_be = 0.

## Structure
- Add DownNarrowWidth and a beat-index type to the xadac_ex_if package. Reuse AddrT, IdT, VectorT and BeT from that package.
- One sub-module: xadac_beat_picker. It is combinational and returns the lowest set enable-slice index at or above a given k, plus a "none" flag. It is only instantiated when the macro is defined.

## Test plan
- Full write: addr 0x1000, be all-ones, zero-wait memory.
  - Expect 8 beats at 0x1000..0x101C with the matching wdata words.
  - Expect s_rvalid at cycle 17 with s_rid = aid.
- Read with rdata word k = 0xA0+k.
  - Expect s_rdata word k = 0xA0+k.
  - Expect m_we = 0 on every beat.
- m_gnt delayed 3 cycles on beat 2.
  - m_req and m_addr 0x1008 must hold stable throughout the delay.
  - Response is delayed by exactly 3 cycles.
- With the macro defined, be = 0x0000000F (vactv imm = 4).
  - Expect a single beat at addr, m_be = 0xF.
  - Expect s_rvalid at cycle 3.
  - With be = 0, no m_req is issued and s_rvalid is asserted at cycle 1.
- m_err asserted on beat 5 only.
  - Expect s_err = 1.
  - The following transaction has s_err = 0.
- rst asserted during WAIT of beat 3.
  - m_req and s_rvalid are 0 after the edge.
  - A late m_rvalid is ignored.
  - The next request completes normally.
